// File: rtl/tea_mux_pkg.sv
// Shared definitions for the TinyEncrypt packet multiplexer: FSM states, mode codes
// and a width helper that can be used in parameter declarations.
package tea_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Never returns 0 so that a channel index always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotates the request vector so the channel after i_ptr sits at
// bit 0, takes the lowest set bit, then maps that offset back to a channel number.
module rr_pick
    import tea_mux_pkg::*;
#(
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [SEL_W-1:0]    i_ptr,
    output logic [SEL_W-1:0]    o_gnt_idx,
    output logic                o_gnt_any
);

    logic [SEL_W-1:0]    w_start;
    logic [CHANNELS-1:0] w_rot;
    logic [SEL_W-1:0]    w_off;
    logic                w_hit;
    logic [SEL_W:0]      w_sum;

    // CHANNELS need not be a power of two, so wrap explicitly instead of relying on overflow.
    always_comb begin
        if (i_ptr == SEL_W'(CHANNELS - 1)) begin
            w_start = '0;
        end else begin
            w_start = i_ptr + SEL_W'(1);
        end
    end

    always_comb begin
        w_rot = CHANNELS'({i_req, i_req} >> w_start);
    end

    always_comb begin
        w_off = '0;
        w_hit = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_W'(i);
                w_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, w_start} + {1'b0, w_off};
        if (w_sum >= (SEL_W + 1)'(CHANNELS)) begin
            w_sum = w_sum - (SEL_W + 1)'(CHANNELS);
        end
    end

    assign o_gnt_idx = w_sum[SEL_W-1:0];
    assign o_gnt_any = w_hit;

endmodule

// File: rtl/pkt_mux.sv
// Packet multiplexer: grants one input channel (SEL-directed or round-robin), holds the
// grant until the LAST beat, and forwards beats through a single output register stage.
module pkt_mux
    import tea_mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_sel,
    input  logic [CHANNELS*WIDTH-1:0] i_in_data,
    input  logic [CHANNELS-1:0]       i_in_valid,
    input  logic [CHANNELS-1:0]       i_in_last,
    output logic [CHANNELS-1:0]       o_in_ready,
    output logic [WIDTH-1:0]          o_out_data,
    output logic                      o_out_valid,
    output logic                      o_out_last,
    output logic [SEL_W-1:0]          o_out_ch,
    input  logic                      i_out_ready
);

    state_t           r_state;
    logic [SEL_W-1:0] r_lock_ch;
    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic [SEL_W-1:0] r_out_ch;

    logic             w_ld;
    logic             w_sel_ok;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_rr_any;
    logic [SEL_W-1:0] w_gnt;
    logic             w_gnt_ok;
    logic [WIDTH-1:0] w_data;
    logic             w_valid;
    logic             w_last;
    logic             w_xfer;

    assign w_ld = !r_out_valid || i_out_ready;

    // A SEL code past the last channel only exists when CHANNELS is not a power of two.
    generate
        if (CHANNELS < (1 << SEL_W)) begin : g_sel_range
            assign w_sel_ok = ({1'b0, i_sel} < (SEL_W + 1)'(CHANNELS));
        end else begin : g_sel_full
            assign w_sel_ok = 1'b1;
        end
    endgenerate

    rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_rr_pick (
        .i_req     (i_in_valid),
        .i_ptr     (r_ptr),
        .o_gnt_idx (w_rr_idx),
        .o_gnt_any (w_rr_any)
    );

    always_comb begin
        w_gnt    = '0;
        w_gnt_ok = 1'b0;
        if (r_state == LOCKED) begin
            w_gnt    = r_lock_ch;
            w_gnt_ok = 1'b1;
        end else if (i_mode == MODE_RR) begin
            w_gnt    = w_rr_idx;
            w_gnt_ok = w_rr_any;
        end else if (w_sel_ok) begin
            w_gnt    = i_sel;
            w_gnt_ok = 1'b1;
        end
    end

    always_comb begin
        w_data  = '0;
        w_valid = 1'b0;
        w_last  = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_gnt == SEL_W'(c)) begin
                w_data  = i_in_data[c*WIDTH +: WIDTH];
                w_valid = i_in_valid[c];
                w_last  = i_in_last[c];
            end
        end
    end

    // Ready is gated by reset so no upstream stage believes a beat was taken during reset.
    always_comb begin
        o_in_ready = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            o_in_ready[c] = w_ld && w_gnt_ok && !i_rst && (w_gnt == SEL_W'(c));
        end
    end

    assign w_xfer = w_ld && w_gnt_ok && w_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_lock_ch   <= '0;
            r_ptr       <= SEL_W'(CHANNELS - 1);
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_data;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last;
            r_out_ch    <= w_gnt;
            if (w_last) begin
                r_state <= IDLE;
                r_ptr   <= w_gnt;
            end else if (r_state == IDLE) begin
                r_state   <= LOCKED;
                r_lock_ch <= w_gnt;
            end
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_out_ch    = r_out_ch;

endmodule

// File: tb/tb_pkt_mux.sv
// Self-checking bench for pkt_mux: directed scenarios plus a randomized run, all compared
// against a transfer-level reference model of the arbitration and output register.
module tb_pkt_mux;

    localparam int W   = 8;
    localparam int CH  = 8;
    localparam int CH5 = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [2:0]  sel;
    logic [63:0] inData;
    logic [7:0]  inValid;
    logic [7:0]  inLast;
    logic [7:0]  inReady;
    logic        outReady;
    logic [7:0]  outData;
    logic        outValid;
    logic        outLast;
    logic [2:0]  outCh;

    logic        mode5;
    logic [2:0]  sel5;
    logic [39:0] inData5;
    logic [4:0]  inValid5;
    logic [4:0]  inLast5;
    logic [4:0]  inReady5;
    logic        outReady5;
    logic [7:0]  outData5;
    logic        outValid5;
    logic        outLast5;
    logic [2:0]  outCh5;

    int total = 0;
    int bad   = 0;

    bit          mLocked;
    int          mLockCh;
    int          mPtr;
    bit          mOutValid;
    bit          mOutLast;
    logic [7:0]  mOutData;
    int          mOutCh;

    always #5 clk = ~clk;

    pkt_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel),
        .i_in_data(inData), .i_in_valid(inValid), .i_in_last(inLast), .o_in_ready(inReady),
        .o_out_data(outData), .o_out_valid(outValid), .o_out_last(outLast), .o_out_ch(outCh),
        .i_out_ready(outReady)
    );

    pkt_mux #(.WIDTH(W), .CHANNELS(CH5)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_mode(mode5), .i_sel(sel5),
        .i_in_data(inData5), .i_in_valid(inValid5), .i_in_last(inLast5), .o_in_ready(inReady5),
        .o_out_data(outData5), .o_out_valid(outValid5), .o_out_last(outLast5), .o_out_ch(outCh5),
        .i_out_ready(outReady5)
    );

    // Reference model: which channel the rules grant, and what a transfer does.
    function automatic int modelGrant();
        int c;
        if (mLocked) return mLockCh;
        if (mode == 1'b0) return (int'(sel) < CH) ? int'(sel) : -1;
        for (int k = 1; k <= CH; k++) begin
            c = (mPtr + k) % CH;
            if (inValid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [7:0] modelReady();
        int g;
        logic [7:0] r;
        g = modelGrant();
        r = '0;
        if ((!mOutValid || outReady) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [12:0] modelOut();
        return {mOutValid, mOutLast, 3'(mOutCh), mOutData};
    endfunction

    task automatic modelReset();
        mLocked = 0; mLockCh = 0; mPtr = CH - 1;
        mOutValid = 0; mOutLast = 0; mOutData = '0; mOutCh = 0;
    endtask

    task automatic clockEdge();
        int g;
        logic [7:0] r;
        g = modelGrant();
        r = modelReady();
        @(posedge clk);
        if (g >= 0 && r[g] && inValid[g]) begin
            mOutData  = inData[g*W +: W];
            mOutLast  = inLast[g];
            mOutCh    = g;
            mOutValid = 1;
            if (inLast[g]) begin
                mLocked = 0;
                mPtr    = g;
            end else if (!mLocked) begin
                mLocked = 1;
                mLockCh = g;
            end
        end else if (outReady) begin
            mOutValid = 0;
        end
        #1;
    endtask

    task automatic clearInputs();
        inData = '0; inValid = '0; inLast = '0;
    endtask

    task automatic driveBeat(input int c, input logic [7:0] d, input logic v, input logic l);
        inData[c*W +: W] = d;
        inValid[c]       = v;
        inLast[c]        = l;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        modelReset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mode = 1'b0; sel = 3'd0; outReady = 1'b1;
        inData = {8{8'h77}}; inValid = '1; inLast = '0;
        modelReset();
        #2;
        total++;
        if (inReady !== 8'h00) begin bad++; $display("[TB] FAIL reset_ready: got %b want %b", inReady, 8'h00); end
        total++;
        if ({outValid, outLast, outCh, outData} !== 13'h0) begin
            bad++; $display("[TB] FAIL reset_out: got %h want %h", {outValid, outLast, outCh, outData}, 13'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({outValid, outData} !== 9'h0) begin bad++; $display("[TB] FAIL reset_hold: got %h want 0", {outValid, outData}); end
        @(negedge clk);
        clearInputs();
        rst = 1'b0;
    endtask

    task automatic test_sel_packet();
        @(negedge clk);
        mode = 1'b0; sel = 3'd3; outReady = 1'b1;
        inData = {$urandom, $urandom}; inValid = 8'hF7; inLast = '0;
        driveBeat(3, 8'hA1, 1'b1, 1'b0);
        #1;
        total++;
        if (inReady !== 8'h08) begin bad++; $display("[TB] FAIL sel_ready1: got %b want %b", inReady, 8'h08); end
        clockEdge();
        total++;
        if ({outValid, outLast, outCh, outData} !== {1'b1, 1'b0, 3'd3, 8'hA1}) begin
            bad++; $display("[TB] FAIL sel_beat1: got v%b l%b ch%0d d%h want v1 l0 ch3 dA1", outValid, outLast, outCh, outData);
        end
        @(negedge clk);
        driveBeat(3, 8'hA2, 1'b1, 1'b1);
        #1;
        total++;
        if (inReady !== 8'h08) begin bad++; $display("[TB] FAIL sel_ready2: got %b want %b", inReady, 8'h08); end
        clockEdge();
        total++;
        if ({outValid, outLast, outCh, outData} !== {1'b1, 1'b1, 3'd3, 8'hA2}) begin
            bad++; $display("[TB] FAIL sel_beat2: got v%b l%b ch%0d d%h want v1 l1 ch3 dA2", outValid, outLast, outCh, outData);
        end
        @(negedge clk);
        driveBeat(3, 8'h00, 1'b0, 1'b0);
        clockEdge();
        total++;
        if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL sel_drain: got valid %b want 0", outValid); end
        @(negedge clk);
        clearInputs();
    endtask

    task automatic test_round_robin();
        int order[3] = '{0, 2, 5};
        pulseReset();
        @(negedge clk);
        mode = 1'b1; outReady = 1'b1;
        clearInputs();
        driveBeat(0, 8'h30, 1'b1, 1'b1);
        driveBeat(2, 8'h32, 1'b1, 1'b1);
        driveBeat(5, 8'h35, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            #1;
            total++;
            if (inReady !== modelReady()) begin bad++; $display("[TB] FAIL rr_ready[%0d]: got %b want %b", i, inReady, modelReady()); end
            clockEdge();
            total++;
            if ({outValid, int'(outCh)} !== {1'b1, order[i%3]}) begin
                bad++; $display("[TB] FAIL rr_order[%0d]: got v%b ch%0d want v1 ch%0d", i, outValid, outCh, order[i%3]);
            end
            total++;
            if ({outValid, outLast, outCh, outData} !== modelOut()) begin
                bad++; $display("[TB] FAIL rr_model[%0d]: got %h want %h", i, {outValid, outLast, outCh, outData}, modelOut());
            end
            @(negedge clk);
        end
        clearInputs();
    endtask

    task automatic test_lock();
        int expCh[4] = '{1, 1, 1, 4};
        logic expLast[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        pulseReset();
        @(negedge clk);
        mode = 1'b1; outReady = 1'b1;
        clearInputs();
        driveBeat(4, 8'h44, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) driveBeat(1, 8'hB1 + 8'(i), 1'b1, i == 2);
            else       driveBeat(1, 8'h00, 1'b0, 1'b0);
            clockEdge();
            total++;
            if ({outValid, outLast, int'(outCh)} !== {1'b1, expLast[i], expCh[i]}) begin
                bad++; $display("[TB] FAIL lock_seq[%0d]: got v%b l%b ch%0d want v1 l%b ch%0d", i, outValid, outLast, outCh, expLast[i], expCh[i]);
            end
            total++;
            if ({outValid, outLast, outCh, outData} !== modelOut()) begin
                bad++; $display("[TB] FAIL lock_model[%0d]: got %h want %h", i, {outValid, outLast, outCh, outData}, modelOut());
            end
            @(negedge clk);
        end
        clearInputs();
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 3'd2; outReady = 1'b1;
        clearInputs();
        driveBeat(2, 8'h5C, 1'b1, 1'b1);
        clockEdge();
        total++;
        if ({outValid, outData} !== {1'b1, 8'h5C}) begin bad++; $display("[TB] FAIL bp_load: got v%b d%h want v1 d5c", outValid, outData); end
        @(negedge clk);
        outReady = 1'b0;
        driveBeat(2, 8'h11, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (inReady !== 8'h00) begin bad++; $display("[TB] FAIL bp_ready[%0d]: got %b want 0", i, inReady); end
            clockEdge();
            total++;
            if ({outValid, outLast, outCh, outData} !== {1'b1, 1'b1, 3'd2, 8'h5C}) begin
                bad++; $display("[TB] FAIL bp_hold[%0d]: got %h want %h", i, {outValid, outLast, outCh, outData}, {1'b1, 1'b1, 3'd2, 8'h5C});
            end
            @(negedge clk);
        end
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            driveBeat(2, 8'h20 + 8'(i), 1'b1, 1'b1);
            #1;
            total++;
            if (inReady !== 8'h04) begin bad++; $display("[TB] FAIL bp_resume_ready[%0d]: got %b want %b", i, inReady, 8'h04); end
            clockEdge();
            total++;
            if ({outValid, outData} !== {1'b1, 8'h20 + 8'(i)}) begin
                bad++; $display("[TB] FAIL bp_resume[%0d]: got v%b d%h want v1 d%h", i, outValid, outData, 8'h20 + 8'(i));
            end
            @(negedge clk);
        end
        clearInputs();
    endtask

    task automatic test_bad_sel();
        @(negedge clk);
        mode5 = 1'b0; sel5 = 3'd6; outReady5 = 1'b1;
        inData5 = {8'h4D, 8'h3D, 8'h2D, 8'h1D, 8'h0D}; inValid5 = '1; inLast5 = '1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sel5 = 3'd7;
            #1;
            total++;
            if (inReady5 !== 5'b0) begin bad++; $display("[TB] FAIL badsel_ready[%0d]: got %b want 0", i, inReady5); end
            @(posedge clk); #1;
            total++;
            if (outValid5 !== 1'b0) begin bad++; $display("[TB] FAIL badsel_valid[%0d]: got %b want 0", i, outValid5); end
            @(negedge clk);
        end
        sel5 = 3'd4;
        #1;
        total++;
        if (inReady5 !== 5'b10000) begin bad++; $display("[TB] FAIL sel4_ready: got %b want 10000", inReady5); end
        @(posedge clk); #1;
        total++;
        if ({outValid5, outCh5, outData5} !== {1'b1, 3'd4, 8'h4D}) begin
            bad++; $display("[TB] FAIL sel4_out: got v%b ch%0d d%h want v1 ch4 d4d", outValid5, outCh5, outData5);
        end
        @(negedge clk);
        inValid5 = '0;
    endtask

    task automatic test_reset_mid_packet();
        pulseReset();
        @(negedge clk);
        mode = 1'b1; outReady = 1'b1;
        clearInputs();
        driveBeat(6, 8'h61, 1'b1, 1'b0);
        clockEdge();
        total++;
        if ({outValid, outLast, outCh, outData} !== {1'b1, 1'b0, 3'd6, 8'h61}) begin
            bad++; $display("[TB] FAIL rstmid_beat1: got %h want %h", {outValid, outLast, outCh, outData}, {1'b1, 1'b0, 3'd6, 8'h61});
        end
        @(negedge clk);
        driveBeat(6, 8'h62, 1'b1, 1'b0);
        driveBeat(0, 8'h0A, 1'b1, 1'b1);
        #1 rst = 1'b1;
        #1;
        total++;
        if ({inReady, outValid, outLast, outData} !== 18'h0) begin
            bad++; $display("[TB] FAIL rstmid_clear: got rdy%b v%b l%b d%h want all 0", inReady, outValid, outLast, outData);
        end
        modelReset();
        #1 rst = 1'b0;
        #1;
        total++;
        if (inReady !== 8'h01) begin bad++; $display("[TB] FAIL rstmid_first: got %b want %b", inReady, 8'h01); end
        clockEdge();
        total++;
        if ({outValid, outLast, outCh, outData} !== {1'b1, 1'b1, 3'd0, 8'h0A}) begin
            bad++; $display("[TB] FAIL rstmid_ch0: got %h want %h", {outValid, outLast, outCh, outData}, {1'b1, 1'b1, 3'd0, 8'h0A});
        end
        @(negedge clk);
        driveBeat(0, 8'h00, 1'b0, 1'b0);
        clockEdge();
        total++;
        if ({outValid, outLast, outCh, outData} !== {1'b1, 1'b0, 3'd6, 8'h62}) begin
            bad++; $display("[TB] FAIL rstmid_new1: got %h want %h", {outValid, outLast, outCh, outData}, {1'b1, 1'b0, 3'd6, 8'h62});
        end
        @(negedge clk);
        driveBeat(6, 8'h63, 1'b1, 1'b1);
        clockEdge();
        total++;
        if ({outValid, outLast, outCh, outData} !== {1'b1, 1'b1, 3'd6, 8'h63}) begin
            bad++; $display("[TB] FAIL rstmid_new2: got %h want %h", {outValid, outLast, outCh, outData}, {1'b1, 1'b1, 3'd6, 8'h63});
        end
        @(negedge clk);
        clearInputs();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
            sel      = 3'($urandom_range(0, 7));
            inData   = {$urandom, $urandom};
            inValid  = 8'($urandom);
            for (int c = 0; c < CH; c++) inLast[c] = ($urandom_range(0, 2) == 0);
            outReady = ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if (inReady !== modelReady()) begin
                bad++; errs++;
                if (errs < 10) $display("[TB] FAIL rand_ready[%0d]: got %b want %b", i, inReady, modelReady());
            end
            clockEdge();
            total++;
            if ({outValid, outLast, outCh, outData} !== modelOut()) begin
                bad++; errs++;
                if (errs < 10) $display("[TB] FAIL rand_out[%0d]: got %h want %h", i, {outValid, outLast, outCh, outData}, modelOut());
            end
        end
        @(negedge clk);
        clearInputs();
    endtask

    initial begin
        mode5 = 1'b0; sel5 = 3'd0; inData5 = '0; inValid5 = '0; inLast5 = '0; outReady5 = 1'b1;
        test_reset();
        test_sel_packet();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_bad_sel();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pkt_mux.md
# pkt_mux

Parametrised CHANNELS:1 packet multiplexer with valid/ready handshakes and a registered output. It selects one input stream, either directed by SEL or by round-robin arbitration, and holds that channel for a whole packet, delimited by LAST. It sits between the per-block TinyEncrypt datapath stages and the shared output/bus interface, superseding the fixed 8-bit 8:1 selectors.

## Interface
- WIDTH, 8: data width per channel in bits.
- CHANNELS, 8: number of input channels, 2..16; need not be a power of two.
- SEL_W, $clog2(CHANNELS): derived localparam, width of the SEL and OUT_CH ports.

- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- MODE  in  1  0 = SEL-directed, 1 = round-robin.
- SEL  in  SEL_W  requested channel in MODE=0.
- IN_DATA  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- IN_VALID  in  CHANNELS  per-channel beat valid.
- IN_LAST  in  CHANNELS  per-channel last beat of packet.
- IN_READY  out  CHANNELS  per-channel accept; combinational.
- OUT_DATA  out  WIDTH  registered data.
- OUT_VALID  out  1  registered valid.
- OUT_LAST  out  1  registered last.
- OUT_CH  out  SEL_W  source channel of the current output beat.
- OUT_READY  in  1  downstream accept.

## Operation
- Load enable: LD = !OUT_VALID || OUT_READY.
- Beat transfer on channel g: IN_VALID[g] && IN_READY[g]. Only IN_READY[g] may be 1; it is set only when LD is 1 and g is granted. While RST is high, all IN_READY bits are 0.
- States: IDLE and LOCKED. Also holds a register LOCK_CH (SEL_W bits) and a round-robin pointer PTR.
- IDLE, MODE=0: grant = SEL. If SEL >= CHANNELS, nothing is granted and IN_READY is all 0.
- IDLE, MODE=1: grant = first channel with IN_VALID=1, scanning PTR+1, PTR+2, … and wrapping modulo CHANNELS. No valid channel means no grant.
- LOCKED: grant = LOCK_CH. MODE and SEL are ignored.
- Transfer with IN_LAST=0 in IDLE: go to LOCKED and set LOCK_CH <= g.
- Transfer with IN_LAST=1, in either state: go to (or stay in) IDLE and set PTR <= g. PTR updates in both modes.
- A single-beat packet, with LAST on its first beat, never enters LOCKED.
- A locked channel that drops IN_VALID mid-packet stalls the mux. The mux stays LOCKED and grants no other channel.
- On transfer: OUT_DATA, OUT_LAST and OUT_CH load from channel g, and OUT_VALID <= 1.
- When OUT_READY=1 and no transfer occurs: OUT_VALID <= 0. OUT_DATA, OUT_LAST and OUT_CH hold their values.
- When OUT_VALID=1 and OUT_READY=0: every output holds stable and IN_READY is all 0.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, OUT_CH=0, state IDLE, LOCK_CH=0, PTR=CHANNELS-1, so channel 0 has first priority after reset.
- Latency: an input beat transferred at edge N is presented on the outputs from edge N onward, i.e. one register stage.
- Throughput: one beat per cycle while OUT_READY=1.
- Back-to-back packets are switched with no bubble: on the cycle LAST transfers, the next cycle arbitrates in IDLE.
- MODE or SEL changing during LOCKED takes effect only after the LAST beat transfers.
- RST asserted mid-packet forces IDLE immediately. The partial packet is dropped: OUT_VALID=0, and no LAST is emitted.
- MODE=1 with a single requester: that channel is granted every arbitration, regardless of PTR.
- PTR wrap: with PTR=CHANNELS-1, the scan order starts at channel 0.

## Structure
- Shared package tea_mux_pkg holds:
  - state encoding: IDLE=1'b0, LOCKED=1'b1;
  - mode constants: MODE_SEL=1'b0, MODE_RR=1'b1;
  - clog2 helper function.
- Sub-module rr_pick: combinational, parameter CHANNELS. Inputs REQ[CHANNELS] and PTR; outputs GNT_IDX and GNT_ANY. Implement it as a rotate, then fixed-priority encode, then un-rotate.
- pkt_mux holds the FSM, LOCK_CH, PTR, the output register and the IN_READY decode.

## Test plan
- Reset, then MODE=0, SEL=3, channel 3 sends a 2-beat packet 0xA1, 0xA2 with OUT_READY=1. Required: OUT_DATA=0xA1 then 0xA2 on consecutive cycles, OUT_CH=3, OUT_LAST=1 on the second beat, and IN_READY[3] is the only bit ever set.
- MODE=1, channels 0, 2 and 5 each hold a 1-beat packet continuously. Required: grant order 0, 2, 5, 0, … with no idle cycles, and PTR wrapping after 5.
- MODE=1, channel 1 sends a 3-beat packet; channel 4 is valid throughout. Required: all 3 beats come from channel 1 before any channel-4 beat, and channel 4 is granted on the next cycle.
- OUT_READY held at 0 for 4 cycles while OUT_VALID=1 with data 0x5C. Required: outputs stable at 0x5C and IN_READY all 0; then one beat per cycle once OUT_READY=1.
- CHANNELS=5 instance with MODE=0 and SEL=6. Required: IN_READY=0 and OUT_VALID stays 0.
- RST pulsed after the first beat of a 3-beat packet. Required: OUT_VALID=0 and state IDLE. The next arbitration starts from channel 0 and the remaining beats are accepted as a new packet.
